// File: rtl/ws2812_rx_pkg.sv
// Shared types and timing helper for the WS2812 receive path.
package ws2812_pkg;

  typedef enum logic [1:0] {
    S_RESYNC = 2'd0,
    S_LOW    = 2'd1,
    S_HIGH   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SHORT   = 2'd1,
    ERR_LONG    = 2'd2,
    ERR_PARTIAL = 2'd3
  } err_t;

  // Truncating ns -> clk cycles; 64-bit intermediate keeps large gaps from overflowing.
  function automatic int ns_to_cycles(input longint clk_hz, input longint ns);
    longint c;
    c = ((clk_hz / 1000) * ns) / 1_000_000;
    return int'(c);
  endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// Decoded-pixel / frame / error event bundle produced by ws2812_rx.
interface ws2812_rx_if;
  logic        pixel_valid;
  logic [23:0] pixel_grb;
  logic [15:0] pixel_index;
  logic        frame_done;
  logic [15:0] pixel_count;
  logic        err_pulse;
  logic [1:0]  err_code;

  modport master (
    output pixel_valid, pixel_grb, pixel_index,
           frame_done, pixel_count, err_pulse, err_code
  );

  modport slave (
    input  pixel_valid, pixel_grb, pixel_index,
           frame_done, pixel_count, err_pulse, err_code
  );
endinterface

// File: rtl/ws2812_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ws2812_rx.sv
// WS2812 NRZ line decoder: pulse-width classification into GRB pixels,
// per-frame pixel counting and framing-error reporting.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int CLK_HZ        = 27_000_000,
  parameter int BIT_THRESH_NS = 600,
  parameter int MIN_HIGH_NS   = 100,
  parameter int MAX_HIGH_NS   = 2000,
  parameter int RESET_NS      = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        din,
  ws2812_rx_if.master rx
);

  localparam int THRESH_CYC = ns_to_cycles(CLK_HZ, BIT_THRESH_NS);
  localparam int MIN_CYC    = ns_to_cycles(CLK_HZ, MIN_HIGH_NS);
  localparam int MAX_CYC    = ns_to_cycles(CLK_HZ, MAX_HIGH_NS);
  localparam int RESET_CYC  = ns_to_cycles(CLK_HZ, RESET_NS);
  localparam int CW         = $clog2(RESET_CYC + 1);

  localparam logic [CW-1:0] THRESH_C = CW'(THRESH_CYC);
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_CYC);
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_CYC);
  localparam logic [CW-1:0] RESET_C  = CW'(RESET_CYC);
  localparam logic [CW-1:0] RESET_M1 = CW'(RESET_CYC - 1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic          din_s;
  logic          din_d;
  logic          rise;
  logic          fall;
  logic          bit_val;

  state_t        state;
  logic [CW-1:0] low_cnt;
  logic [CW-1:0] high_cnt;
  logic [22:0]   shift;
  logic [4:0]    bit_cnt;
  logic [15:0]   idx;
  logic          fd_pend;

  logic          pv_q;
  logic [23:0]   grb_q;
  logic [15:0]   pidx_q;
  logic          fd_q;
  logic [15:0]   pcnt_q;
  logic          err_q;
  err_t          ecode_q;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (din),
    .q     (din_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) din_d <= 1'b0;
    else          din_d <= din_s;
  end

  assign rise    = din_s & ~din_d;
  assign fall    = ~din_s & din_d;
  assign bit_val = (high_cnt >= THRESH_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_RESYNC;
      low_cnt  <= '0;
      high_cnt <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
      idx      <= '0;
      fd_pend  <= 1'b0;
      pv_q     <= 1'b0;
      grb_q    <= '0;
      pidx_q   <= '0;
      fd_q     <= 1'b0;
      pcnt_q   <= '0;
      err_q    <= 1'b0;
      ecode_q  <= ERR_NONE;
    end else begin
      pv_q  <= 1'b0;
      fd_q  <= 1'b0;
      err_q <= 1'b0;

      // Frame end that coincided with a partial-pixel error reports one cycle later.
      if (fd_pend) begin
        fd_pend <= 1'b0;
        if (idx != 16'd0) begin
          fd_q   <= 1'b1;
          pcnt_q <= idx;
          idx    <= '0;
        end
      end

      unique case (state)
        S_RESYNC: begin
          if (din_s) begin
            low_cnt <= '0;
          end else if (low_cnt == RESET_M1) begin
            low_cnt <= RESET_C;
            state   <= S_LOW;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end

        S_LOW: begin
          if (rise) begin
            state    <= S_HIGH;
            high_cnt <= ONE_C;
          end else if (low_cnt != RESET_C) begin
            low_cnt <= low_cnt + 1'b1;
            if (low_cnt == RESET_M1) begin
              if (bit_cnt != 5'd0) begin
                err_q   <= 1'b1;
                ecode_q <= ERR_PARTIAL;
                bit_cnt <= '0;
                fd_pend <= 1'b1;
              end else if (idx != 16'd0) begin
                fd_q   <= 1'b1;
                pcnt_q <= idx;
                idx    <= '0;
              end
            end
          end
        end

        S_HIGH: begin
          if (fall) begin
            state   <= S_LOW;
            low_cnt <= ONE_C;
            if (high_cnt < MIN_C) begin
              err_q   <= 1'b1;
              ecode_q <= ERR_SHORT;
              state   <= S_RESYNC;
              bit_cnt <= '0;
              idx     <= '0;
            end else begin
              shift <= {shift[21:0], bit_val};
              if (bit_cnt == 5'd23) begin
                pv_q    <= 1'b1;
                grb_q   <= {shift, bit_val};
                pidx_q  <= idx;
                bit_cnt <= '0;
                if (idx != 16'hFFFF) idx <= idx + 16'd1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end else if (high_cnt == MAX_C) begin
            // Still high one cycle past the limit: stuck line, abandon the frame now.
            err_q   <= 1'b1;
            ecode_q <= ERR_LONG;
            state   <= S_RESYNC;
            low_cnt <= '0;
            bit_cnt <= '0;
            idx     <= '0;
          end else begin
            high_cnt <= high_cnt + 1'b1;
          end
        end

        default: state <= S_RESYNC;
      endcase
    end
  end

  assign rx.pixel_valid = pv_q;
  assign rx.pixel_grb   = grb_q;
  assign rx.pixel_index = pidx_q;
  assign rx.frame_done  = fd_q;
  assign rx.pixel_count = pcnt_q;
  assign rx.err_pulse   = err_q;
  assign rx.err_code    = ecode_q;

endmodule
